// File: rtl/hand_layout.sv
// Feeder for the card print engine: buffers deal events, tracks per-hand card counts,
// computes card origins and issues one write/init request at a time to the engine.
module hand_layout #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_CARDS  = 8,
  parameter int unsigned X0         = 4,
  parameter int unsigned CARD_W     = 10,
  parameter int unsigned DEALER_Y   = 8,
  parameter int unsigned PLAYER_Y   = 70
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_round,
  input  logic        deal_valid,
  output logic        deal_ready,
  input  logic        deal_who,
  input  logic [5:0]  deal_card,
  output logic        write,
  output logic        init,
  output logic [5:0]  card,
  output logic [14:0] orig,
  input  logic        waitrequest,
  output logic [3:0]  dealer_count,
  output logic [3:0]  player_count,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StInitReq, StCardReq, StSettle, StWait} state_e;

  state_e state_q, state_d;

  logic [6:0]  mem [FIFO_DEPTH];
  logic [AW:0] rd_ptr_q, wr_ptr_q;
  logic        empty, full, push, pop;
  logic        head_who;
  logic [5:0]  head_card;
  logic [3:0]  head_cnt;
  logic [7:0]  x_calc;
  logic [6:0]  y_calc;

  logic        pending_init_q;
  logic        init_q;
  logic [5:0]  card_q;
  logic [14:0] orig_q;
  logic        cur_who_q;
  logic [3:0]  dealer_count_q, player_count_q;
  logic        overflow_q;

  logic load_init, load_card, set_ovf, inc_count;

  assign empty      = (rd_ptr_q == wr_ptr_q);
  assign full       = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
  assign deal_ready = !full;
  assign push       = deal_valid && deal_ready;

  assign {head_who, head_card} = mem[rd_ptr_q[AW-1:0]];
  assign head_cnt = head_who ? player_count_q : dealer_count_q;
  assign x_calc   = 8'(X0) + 8'(head_cnt) * 8'(CARD_W);
  assign y_calc   = head_who ? 7'(PLAYER_Y) : 7'(DEALER_Y);

  // A new_round push lands in slot 0 of the freshly flushed FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[new_round ? '0 : wr_ptr_q[AW-1:0]] <= {deal_who, deal_card};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (new_round) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= {{AW{1'b0}}, push};
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_init = 1'b0;
    load_card = 1'b0;
    set_ovf   = 1'b0;
    inc_count = 1'b0;
    case (state_q)
      StIdle: begin
        // new_round counts as pending so no stale card is popped in its cycle.
        if (!waitrequest) begin
          if (pending_init_q || new_round) begin
            state_d   = StInitReq;
            load_init = 1'b1;
          end else if (!empty) begin
            pop = 1'b1;
            if (32'(head_cnt) < MAX_CARDS) begin
              state_d   = StCardReq;
              load_card = 1'b1;
            end else begin
              set_ovf = 1'b1;
            end
          end
        end
      end
      StInitReq: state_d = StSettle;
      StCardReq: begin
        state_d   = StSettle;
        inc_count = 1'b1;
      end
      StSettle:  state_d = StWait;
      StWait:    if (!waitrequest) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      pending_init_q <= 1'b0;
      init_q         <= 1'b0;
      card_q         <= '0;
      orig_q         <= '0;
      cur_who_q      <= 1'b0;
      dealer_count_q <= '0;
      player_count_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (new_round)                  pending_init_q <= 1'b1;
      else if (state_q == StInitReq)  pending_init_q <= 1'b0;

      if (load_init) init_q <= 1'b1;
      if (load_card) begin
        init_q    <= 1'b0;
        card_q    <= head_card;
        orig_q    <= {x_calc, y_calc};
        cur_who_q <= head_who;
      end

      if (new_round) begin
        dealer_count_q <= '0;
        player_count_q <= '0;
        overflow_q     <= 1'b0;
      end else begin
        if (set_ovf) overflow_q <= 1'b1;
        if (inc_count) begin
          if (cur_who_q) player_count_q <= player_count_q + 4'd1;
          else           dealer_count_q <= dealer_count_q + 4'd1;
        end
      end
    end
  end

  // Decoded from state so an asynchronous reset drops the request immediately.
  assign write        = (state_q == StInitReq) || (state_q == StCardReq);
  assign init         = init_q;
  assign card         = card_q;
  assign orig         = orig_q;
  assign dealer_count = dealer_count_q;
  assign player_count = player_count_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != StIdle) || !empty || pending_init_q;

endmodule
